// File: rtl/rv_retire_checker.sv
// Lockstep retirement checker: shadows decode->wr of the RV32 core and compares each retirement
// against expected records queued through a valid/ready FIFO, latching the first mismatch.
module rv_retire_checker #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned EXP_DEPTH        = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic [IADDR_SPACE_BITS-1:0]   i_pc,
    input  logic [31:0]                   i_instr,
    input  logic                          i_reg_write,
    input  logic                          i_exec_flush,
    input  logic                          i_exec2_flush,
    input  logic [31:0]                   i_reg_data,
    input  logic                          i_exp_valid,
    output logic                          o_exp_ready,
    input  logic [IADDR_SPACE_BITS-1:0]   i_exp_pc,
    input  logic [31:0]                   i_exp_instr,
    input  logic                          i_exp_rd_we,
    input  logic [31:0]                   i_exp_rd_data,
    output logic [$clog2(EXP_DEPTH):0]    o_exp_level,
    output logic [1:0]                    o_state,
    output logic [31:0]                   o_retire_cnt,
    output logic                          o_mismatch,
    output logic [3:0]                    o_fail_code,
    output logic [IADDR_SPACE_BITS-1:0]   o_fail_pc,
    output logic [31:0]                   o_fail_data
);

    localparam int unsigned PtrW = $clog2(EXP_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFail = 2'd2
    } state_e;

    // Shadow pipeline
    logic [IADDR_SPACE_BITS-1:0] ex_pc_q, e2_pc_q, mem_pc_q, wr_pc_q;
    logic [31:0]                 ex_instr_q, e2_instr_q, mem_instr_q, wr_instr_q;
    logic                        ex_we_q, e2_we_q, mem_we_q, wr_we_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_pc_q     <= '0;
            ex_instr_q  <= '0;
            ex_we_q     <= 1'b0;
            e2_pc_q     <= '0;
            e2_instr_q  <= '0;
            e2_we_q     <= 1'b0;
            mem_pc_q    <= '0;
            mem_instr_q <= '0;
            mem_we_q    <= 1'b0;
            wr_pc_q     <= '0;
            wr_instr_q  <= '0;
            wr_we_q     <= 1'b0;
        end else begin
            ex_pc_q     <= i_exec_flush ? '0 : i_pc;
            ex_instr_q  <= i_exec_flush ? '0 : i_instr;
            ex_we_q     <= i_exec_flush ? 1'b0 : i_reg_write;
            e2_pc_q     <= i_exec2_flush ? '0 : ex_pc_q;
            e2_instr_q  <= i_exec2_flush ? '0 : ex_instr_q;
            e2_we_q     <= i_exec2_flush ? 1'b0 : ex_we_q;
            mem_pc_q    <= e2_pc_q;
            mem_instr_q <= e2_instr_q;
            mem_we_q    <= e2_we_q;
            wr_pc_q     <= mem_pc_q;
            wr_instr_q  <= mem_instr_q;
            wr_we_q     <= mem_we_q;
        end
    end

    // Expected-record FIFO; storage is not reset
    logic [IADDR_SPACE_BITS-1:0] fifo_pc    [EXP_DEPTH];
    logic [31:0]                 fifo_instr [EXP_DEPTH];
    logic                        fifo_we    [EXP_DEPTH];
    logic [31:0]                 fifo_data  [EXP_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]             level_q;
    logic                        push, pop, fifo_empty;

    assign o_exp_ready = (level_q != LvlW'(EXP_DEPTH));
    assign o_exp_level = level_q;
    assign fifo_empty  = (level_q == '0);
    assign push        = i_exp_valid && o_exp_ready;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= i_exp_pc;
            fifo_instr[wr_ptr_q] <= i_exp_instr;
            fifo_we[wr_ptr_q]    <= i_exp_rd_we;
            fifo_data[wr_ptr_q]  <= i_exp_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    // Retirement compare
    state_e      state_q;
    logic        retire, check_en;
    logic [3:0]  fail_code;

    assign retire   = (wr_instr_q != '0);
    assign check_en = (state_q == StRun) && retire;
    assign pop      = check_en && !fifo_empty;

    always_comb begin
        fail_code = 4'b0000;
        if (fifo_empty) begin
            fail_code[3] = 1'b1;
        end else begin
            fail_code[0] = (wr_pc_q != fifo_pc[rd_ptr_q]);
            fail_code[1] = (wr_instr_q != fifo_instr[rd_ptr_q]);
            // Writes to x0 are architecturally discarded, so their data is not compared
            fail_code[2] = (wr_we_q != fifo_we[rd_ptr_q]) ||
                           (wr_we_q && (wr_instr_q[11:7] != 5'd0) &&
                            (i_reg_data != fifo_data[rd_ptr_q]));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            o_retire_cnt <= '0;
            o_mismatch   <= 1'b0;
            o_fail_code  <= '0;
            o_fail_pc    <= '0;
            o_fail_data  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_enable) state_q <= StRun;
                end
                StRun: begin
                    if (check_en) begin
                        if (fail_code != 4'b0000) begin
                            state_q     <= StFail;
                            o_mismatch  <= 1'b1;
                            o_fail_code <= fail_code;
                            o_fail_pc   <= wr_pc_q;
                            o_fail_data <= i_reg_data;
                        end else begin
                            o_retire_cnt <= o_retire_cnt + 32'd1;
                        end
                    end
                end
                default: state_q <= StFail;
            endcase
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_rv_retire_checker.sv
// Randomized and directed bench for rv_retire_checker against a queue-based retirement model.
module tb_rv_retire_checker;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_enable = 1'b0;
    logic [AW-1:0] i_pc = '0;
    logic [31:0]   i_instr = '0;
    logic          i_reg_write = 1'b0;
    logic          i_exec_flush = 1'b0;
    logic          i_exec2_flush = 1'b0;
    logic [31:0]   i_reg_data = '0;
    logic          i_exp_valid = 1'b0;
    logic [AW-1:0] i_exp_pc = '0;
    logic [31:0]   i_exp_instr = '0;
    logic          i_exp_rd_we = 1'b0;
    logic [31:0]   i_exp_rd_data = '0;
    logic          o_exp_ready;
    logic [3:0]    o_exp_level;
    logic [1:0]    o_state;
    logic [31:0]   o_retire_cnt;
    logic          o_mismatch;
    logic [3:0]    o_fail_code;
    logic [AW-1:0] o_fail_pc;
    logic [31:0]   o_fail_data;

    rv_retire_checker #(.IADDR_SPACE_BITS(AW), .EXP_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_pc(i_pc),
        .i_instr(i_instr), .i_reg_write(i_reg_write), .i_exec_flush(i_exec_flush),
        .i_exec2_flush(i_exec2_flush), .i_reg_data(i_reg_data), .i_exp_valid(i_exp_valid),
        .o_exp_ready(o_exp_ready), .i_exp_pc(i_exp_pc), .i_exp_instr(i_exp_instr),
        .i_exp_rd_we(i_exp_rd_we), .i_exp_rd_data(i_exp_rd_data), .o_exp_level(o_exp_level),
        .o_state(o_state), .o_retire_cnt(o_retire_cnt), .o_mismatch(o_mismatch),
        .o_fail_code(o_fail_code), .o_fail_pc(o_fail_pc), .o_fail_data(o_fail_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [31:0] data;
    } rec_t;

    // Model: in-flight records oldest first (index 0 is in wr), expected queue, checker status
    rec_t        m_pipe[$];
    rec_t        m_exp[$];
    int          m_state;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [3:0]  m_code;
    logic [31:0] m_fpc;
    logic [31:0] m_fdata;
    logic [31:0] drv_data = '0;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic rec_t mk(logic [31:0] pc, logic [31:0] instr, logic we, logic [31:0] data);
        rec_t r;
        r.pc = pc; r.instr = instr; r.we = we; r.data = data;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        repeat (4) m_pipe.push_back(mk(0, 0, 0, 0));
        m_exp.delete();
        m_state = 0; m_cnt = 0; m_mis = 0; m_code = 0; m_fpc = 0; m_fdata = 0;
    endtask

    task automatic model_step();
        rec_t w, h;
        logic [3:0] code;
        bit push_ok, pop;
        int st;
        w = m_pipe[0];
        code = 0; pop = 0; st = m_state;
        push_ok = i_exp_valid && (m_exp.size() < DEPTH);
        if (st == 1 && w.instr != 0) begin
            if (m_exp.size() == 0) code = 4'b1000;
            else begin
                h = m_exp[0];
                pop = 1;
                if (w.pc != h.pc) code[0] = 1;
                if (w.instr != h.instr) code[1] = 1;
                if (w.we != h.we || (w.we && w.instr[11:7] != 0 && i_reg_data != h.data))
                    code[2] = 1;
            end
            if (code != 0) begin
                m_state = 2; m_mis = 1; m_code = code; m_fpc = w.pc; m_fdata = i_reg_data;
            end else m_cnt = m_cnt + 1;
        end
        if (pop) h = m_exp.pop_front();
        if (push_ok) m_exp.push_back(mk(i_exp_pc, i_exp_instr, i_exp_rd_we, i_exp_rd_data));
        if (st == 0 && i_enable) m_state = 1;
        w = m_pipe.pop_front();
        if (i_exec2_flush) m_pipe[2] = mk(0, 0, 0, 0);
        m_pipe.push_back(i_exec_flush ? mk(0, 0, 0, 0) : mk(i_pc, i_instr, i_reg_write, drv_data));
    endtask

    always @(posedge i_clk) begin
        if (!i_reset_n) model_reset();
        else model_step();
    end

    always @(negedge i_reset_n) model_reset();

    // Every-cycle compare, away from the active edge
    always @(negedge i_clk) begin
        check("state", o_state, m_state);
        check("retire_cnt", o_retire_cnt, m_cnt);
        check("mismatch", o_mismatch, m_mis);
        check("fail_code", o_fail_code, m_code);
        check("fail_pc", o_fail_pc, m_fpc);
        check("fail_data", o_fail_data, m_fdata);
        check("exp_level", o_exp_level, m_exp.size());
        check("exp_ready", o_exp_ready, m_exp.size() != DEPTH);
    end

    task automatic idle_inputs();
        i_pc = 0; i_instr = 0; i_reg_write = 0; drv_data = 0;
        i_exec_flush = 0; i_exec2_flush = 0;
        i_exp_valid = 0; i_exp_pc = 0; i_exp_instr = 0; i_exp_rd_we = 0; i_exp_rd_data = 0;
    endtask

    task automatic set_dec(rec_t r);
        i_pc = r.pc; i_instr = r.instr; i_reg_write = r.we; drv_data = r.data;
    endtask

    task automatic clr_dec();
        i_pc = 0; i_instr = 0; i_reg_write = 0; drv_data = 0;
    endtask

    task automatic set_exp(rec_t r);
        i_exp_valid = 1; i_exp_pc = r.pc; i_exp_instr = r.instr;
        i_exp_rd_we = r.we; i_exp_rd_data = r.data;
    endtask

    // The core's writeback data follows the record currently in wr
    task automatic tick();
        i_reg_data = m_pipe[0].data;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        #1 i_reset_n = 0;
        idle_inputs();
        i_enable = 0;
        #1;
        check("rst_state", o_state, 0);
        check("rst_cnt", o_retire_cnt, 0);
        check("rst_mismatch", o_mismatch, 0);
        check("rst_code", o_fail_code, 0);
        check("rst_fpc", o_fail_pc, 0);
        check("rst_fdata", o_fail_data, 0);
        check("rst_level", o_exp_level, 0);
        check("rst_ready", o_exp_ready, 1);
        @(negedge i_clk);
        i_reset_n = 1;
    endtask

    initial begin
        rec_t r, e;
        logic [31:0] pcs[4];
        logic [31:0] ins, pc_ctr;
        int p, en_at, k;
        bit f2;

        model_reset();
        idle_inputs();
        @(negedge i_clk);

        // Four matching addi retirements, then reset while a fifth is mid-compare
        do_reset();
        i_enable = 1;
        for (int i = 0; i < 4; i++) begin
            set_exp(mk(i * 4, 32'h00100093, 1, 1)); tick();
        end
        i_exp_valid = 0;
        for (int i = 0; i < 4; i++) begin
            set_dec(mk(i * 4, 32'h00100093, 1, 1)); tick();
        end
        clr_dec();
        repeat (6) tick();
        check("t1_cnt", o_retire_cnt, 4);
        check("t1_mismatch", o_mismatch, 0);
        check("t1_level", o_exp_level, 0);
        set_exp(mk(32'h10, 32'h00100093, 1, 1));
        set_dec(mk(32'h10, 32'h00100093, 1, 1));
        tick();
        idle_inputs();
        repeat (3) tick();
        do_reset();

        // PC mismatch on the third retirement
        i_enable = 1;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h10; pcs[3] = 32'hC;
        for (int i = 0; i < 4; i++) begin
            set_exp(mk(i * 4, 32'h00100093, 1, 1)); tick();
        end
        i_exp_valid = 0;
        for (int i = 0; i < 4; i++) begin
            set_dec(mk(pcs[i], 32'h00100093, 1, 1)); tick();
        end
        clr_dec();
        repeat (6) tick();
        check("t2_state", o_state, 2);
        check("t2_code", o_fail_code, 4'b0001);
        check("t2_fpc", o_fail_pc, 32'h10);
        check("t2_cnt", o_retire_cnt, 2);

        // Retirement with nothing expected
        do_reset();
        i_enable = 1;
        set_dec(mk(32'h100, 32'h00100093, 1, 7)); tick();
        clr_dec();
        repeat (6) tick();
        check("t3_code", o_fail_code, 4'b1000);
        check("t3_state", o_state, 2);
        check("t3_level", o_exp_level, 0);
        check("t3_fdata", o_fail_data, 7);

        // Fill to full, reject a ninth, then stream push+pop through pointer wrap
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_exp(mk(i * 4, 32'h13 | ((i % 31 + 1) << 7), 1, i)); tick();
        end
        i_exp_valid = 0;
        check("t4_level_full", o_exp_level, 8);
        check("t4_ready_full", o_exp_ready, 0);
        i_enable = 1;
        p = 8;
        for (int c = 0; c < 24; c++) begin
            if (c < 12) set_dec(mk(c * 4, 32'h13 | ((c % 31 + 1) << 7), 1, c));
            else clr_dec();
            if (p < 12 && m_exp.size() < DEPTH) begin
                set_exp(mk(p * 4, 32'h13 | ((p % 31 + 1) << 7), 1, p)); p++;
            end else i_exp_valid = 0;
            tick();
        end
        check("t4_cnt", o_retire_cnt, 12);
        check("t4_level", o_exp_level, 0);
        check("t4_mismatch", o_mismatch, 0);

        // exec2 flush on a branch shadow, exec flush on another
        do_reset();
        i_enable = 1;
        set_exp(mk(32'h40, 32'h00100093, 1, 1)); tick();
        set_exp(mk(32'h48, 32'h00200113, 1, 2)); tick();
        set_exp(mk(32'h50, 32'h00300193, 1, 3)); tick();
        i_exp_valid = 0;
        set_dec(mk(32'h40, 32'h00100093, 1, 1)); tick();
        set_dec(mk(32'h44, 32'h00000463, 0, 0)); tick();
        i_exec2_flush = 1;
        set_dec(mk(32'h48, 32'h00200113, 1, 2)); tick();
        i_exec2_flush = 0;
        i_exec_flush = 1;
        set_dec(mk(32'h4C, 32'h00900213, 1, 9)); tick();
        i_exec_flush = 0;
        set_dec(mk(32'h50, 32'h00300193, 1, 3)); tick();
        clr_dec();
        repeat (6) tick();
        check("t5_cnt", o_retire_cnt, 3);
        check("t5_mismatch", o_mismatch, 0);
        check("t5_level", o_exp_level, 0);

        // rd=x0 data ignored; rd=x5 data mismatch
        do_reset();
        i_enable = 1;
        set_exp(mk(32'h80, 32'h00500013, 1, 32'hBEEF)); tick();
        set_exp(mk(32'h84, 32'h00100293, 1, 32'h1234)); tick();
        i_exp_valid = 0;
        set_dec(mk(32'h80, 32'h00500013, 1, 32'hDEAD)); tick();
        set_dec(mk(32'h84, 32'h00100293, 1, 32'h1235)); tick();
        clr_dec();
        repeat (6) tick();
        check("t6_cnt", o_retire_cnt, 1);
        check("t6_code", o_fail_code, 4'b0100);
        check("t6_fdata", o_fail_data, 32'h1235);
        check("t6_fpc", o_fail_pc, 32'h84);

        // Randomized episodes
        for (int ep = 0; ep < 24; ep++) begin
            e = mk(0, 0, 0, 0);
            do_reset();
            en_at = $urandom_range(1, 5);
            pc_ctr = $urandom & 32'hFFFF_FFFC;
            f2 = 0;
            begin
                rec_t pending[$];
                for (int c = 0; c < 160; c++) begin
                    idle_inputs();
                    i_exec2_flush = f2;
                    f2 = 0;
                    if (c < en_at) i_enable = 0;
                    else if (c < en_at + 2) i_enable = 1;
                    else i_enable = $urandom_range(0, 1);
                    if (c >= en_at && c < 150 && $urandom_range(0, 1) == 1) begin
                        ins = $urandom;
                        if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
                        if (ins == 0) ins = 32'h13;
                        r = mk(pc_ctr, ins, $urandom_range(0, 3) != 0, $urandom);
                        pc_ctr = pc_ctr + 4;
                        set_dec(r);
                        k = $urandom_range(0, 11);
                        if (k == 0) i_exec_flush = 1;
                        else if (k == 1) f2 = 1;
                        else begin
                            e = r;
                            if ($urandom_range(0, 39) == 0) begin
                                case ($urandom_range(0, 3))
                                    0: e.pc = e.pc ^ 32'h4;
                                    1: e.instr = e.instr ^ 32'h0010_0000;
                                    2: e.we = ~e.we;
                                    default: e.data = e.data + 1;
                                endcase
                            end
                            pending.push_back(e);
                        end
                    end else if ($urandom_range(0, 7) == 0) i_exec_flush = 1;
                    if (pending.size() > 0 && $urandom_range(0, 4) != 0 &&
                        m_exp.size() < DEPTH) begin
                        e = pending.pop_front();
                        set_exp(e);
                    end else if (m_exp.size() == DEPTH && $urandom_range(0, 1) == 1) begin
                        set_exp(mk($urandom, $urandom, 1, $urandom));
                    end
                    tick();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
